// File: rtl/pixel_serializer.sv
// Byte-to-bit pixel serializer: a holding register is loaded by LD and drained MSB-first
// through a shift register on clock-enabled edges, back-to-back without gaps.
module pixel_serializer #(
  parameter logic IDLE_BIT = 1'b0
) (
  input  logic       clk,
  input  logic       RESETn,
  input  logic       ce,
  input  logic [7:0] D,
  input  logic       LD,
  input  logic       FLIP,
  input  logic       CLR_OVF,
  output logic       Q,
  output logic       QV,
  output logic       REQ,
  output logic       OVF
);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t     state;
  logic [7:0] hold;
  logic       hfull;
  logic [7:0] sr;
  logic [2:0] cnt;
  logic       ovf;

  logic [7:0] d_rev;
  logic       last_bit;
  logic       xfer;
  logic       ld_ok;
  logic       overrun;

  // NOTE: every signal assigned in always_comb gets a value on every path, so no latch is inferred.
  always_comb begin
    d_rev = '0;
    for (int i = 0; i < 8; i++) d_rev[i] = D[7-i];
  end

  assign last_bit = (cnt == 3'd7);
  // The holding register drains into the shifter when the shifter is idle or on its last bit.
  assign xfer     = ce & hfull & ((state == IDLE) | last_bit);
  // A load is safe if the holding register is empty or is being emptied on this same edge.
  assign ld_ok    = LD & (~hfull | xfer);
  assign overrun  = LD & hfull & ~xfer;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values;
  // this lets a load and a transfer share an edge with SR taking the old HOLD contents.
  always_ff @(posedge clk or negedge RESETn) begin
    if (!RESETn) begin
      state <= IDLE;
      hold  <= '0;
      hfull <= 1'b0;
      sr    <= '0;
      cnt   <= '0;
      ovf   <= 1'b0;
    end else begin
      if (ld_ok) hold <= FLIP ? d_rev : D;

      if (ld_ok)     hfull <= 1'b1;
      else if (xfer) hfull <= 1'b0;

      // Overrun wins over a simultaneous clear.
      if (overrun)      ovf <= 1'b1;
      else if (CLR_OVF) ovf <= 1'b0;

      if (ce) begin
        if (xfer) begin
          sr    <= hold;
          cnt   <= '0;
          state <= SHIFT;
        end else if (state == SHIFT) begin
          if (!last_bit) begin
            sr  <= {sr[6:0], 1'b0};
            cnt <= cnt + 3'd1;
          end else begin
            state <= IDLE;
          end
        end
      end
    end
  end

  assign Q   = (state == SHIFT) ? sr[7] : IDLE_BIT;
  assign QV  = (state == SHIFT);
  assign REQ = ~hfull;
  assign OVF = ovf;

endmodule

// File: tb/tb_pixel_serializer.sv
// Directed self-checking bench for pixel_serializer; outputs are sampled on the falling edge,
// inputs are changed right after sampling.
module tb_pixel_serializer;

  localparam logic IDLE = 1'b1;

  logic       clk;
  logic       RESETn;
  logic       ce;
  logic [7:0] D;
  logic       LD;
  logic       FLIP;
  logic       CLR_OVF;
  logic       Q;
  logic       QV;
  logic       REQ;
  logic       OVF;

  int checks;
  int errors;

  pixel_serializer #(.IDLE_BIT(IDLE)) dut (
    .clk     (clk),
    .RESETn  (RESETn),
    .ce      (ce),
    .D       (D),
    .LD      (LD),
    .FLIP    (FLIP),
    .CLR_OVF (CLR_OVF),
    .Q       (Q),
    .QV      (QV),
    .REQ     (REQ),
    .OVF     (OVF)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Pulse LD for one edge, returning at the falling edge after it.
  task automatic load(input logic [7:0] data, input logic flip);
    LD   = 1'b1;
    D    = data;
    FLIP = flip;
    @(negedge clk);
    LD   = 1'b0;
    FLIP = 1'b0;
    D    = 'x;
  endtask

  // Expect eight valid bits, MSB first, one per falling edge (ce held high).
  task automatic expect_byte(input string tag, input logic [7:0] exp);
    for (int i = 7; i >= 0; i--) begin
      check({tag, "_qv"}, {7'd0, QV}, 8'd1);
      check({tag, "_q"}, {7'd0, Q}, {7'd0, exp[i]});
      @(negedge clk);
    end
  endtask

  task automatic expect_idle(input string tag);
    check({tag, "_idle_qv"}, {7'd0, QV}, 8'd0);
    check({tag, "_idle_q"}, {7'd0, Q}, {7'd0, IDLE});
  endtask

  initial begin
    logic [15:0] pair;
    checks  = 0;
    errors  = 0;
    RESETn  = 1'b0;
    ce      = 1'b0;
    D       = 'x;
    LD      = 1'b0;
    FLIP    = 1'b0;
    CLR_OVF = 1'b0;

    // Reset state
    #3;
    check("rst_q", {7'd0, Q}, {7'd0, IDLE});
    check("rst_qv", {7'd0, QV}, 8'd0);
    check("rst_req", {7'd0, REQ}, 8'd1);
    check("rst_ovf", {7'd0, OVF}, 8'd0);
    @(negedge clk);
    RESETn = 1'b1;
    ce     = 1'b1;

    // A5, no flip: one edge to load, one to transfer, then eight bits
    load(8'hA5, 1'b0);
    check("a5_req_after_ld", {7'd0, REQ}, 8'd0);
    check("a5_qv_before_xfer", {7'd0, QV}, 8'd0);
    @(negedge clk);
    expect_byte("a5", 8'hA5);
    expect_idle("a5");
    check("a5_req_end", {7'd0, REQ}, 8'd1);

    // 01 flipped shifts out as 80
    load(8'h01, 1'b1);
    @(negedge clk);
    expect_byte("flip01", 8'h80);
    expect_idle("flip01");

    // FF then 00 loaded during the first byte: 16 gapless bits
    load(8'hFF, 1'b0);
    @(negedge clk);
    check("b2b_req", {7'd0, REQ}, 8'd1);
    pair = 16'hFF00;
    for (int i = 15; i >= 0; i--) begin
      check("b2b_qv", {7'd0, QV}, 8'd1);
      check("b2b_q", {7'd0, Q}, {7'd0, pair[i]});
      if (i == 15) begin
        LD = 1'b1;
        D  = 8'h00;
      end else begin
        LD = 1'b0;
        D  = 'x;
      end
      @(negedge clk);
    end
    expect_idle("b2b");

    // Overrun with ce low: second and third loads are dropped
    ce = 1'b0;
    load(8'hAA, 1'b0);
    check("ovr_req_full", {7'd0, REQ}, 8'd0);
    check("ovr_ovf_clean", {7'd0, OVF}, 8'd0);
    load(8'h55, 1'b0);
    check("ovr_set", {7'd0, OVF}, 8'd1);
    load(8'h0F, 1'b1);
    repeat (3) @(negedge clk);
    check("ovr_sticky", {7'd0, OVF}, 8'd1);
    check("ovr_no_shift", {7'd0, QV}, 8'd0);
    CLR_OVF = 1'b1;
    @(negedge clk);
    check("ovr_clr", {7'd0, OVF}, 8'd0);
    LD = 1'b1;
    D  = 8'h33;
    @(negedge clk);
    check("ovr_set_wins", {7'd0, OVF}, 8'd1);
    LD = 1'b0;
    D  = 'x;
    @(negedge clk);
    check("ovr_clr2", {7'd0, OVF}, 8'd0);
    CLR_OVF = 1'b0;
    ce      = 1'b1;
    @(negedge clk);
    expect_byte("ovr_kept", 8'hAA);
    expect_idle("ovr_kept");

    // ce one cycle in four: each bit held four clocks
    ce = 1'b0;
    load(8'hC3, 1'b0);
    pair = {8'hC3, 8'h00};
    for (int j = 0; j <= 32; j++) begin
      ce = (j % 4 == 0);
      @(negedge clk);
      if (j < 32) begin
        check("ce4_qv", {7'd0, QV}, 8'd1);
        check("ce4_q", {7'd0, Q}, {7'd0, pair[15 - j / 4]});
      end else begin
        expect_idle("ce4");
      end
    end

    // Reset mid-byte at cnt=3, with OVF and HOLD both populated beforehand
    ce = 1'b0;
    load(8'h0F, 1'b0);
    load(8'h77, 1'b0);
    check("mid_ovf_pre", {7'd0, OVF}, 8'd1);
    ce = 1'b1;
    @(negedge clk);
    load(8'hE7, 1'b0);
    repeat (2) @(negedge clk);
    check("mid_cnt3_qv", {7'd0, QV}, 8'd1);
    check("mid_req_pre", {7'd0, REQ}, 8'd0);
    #2;
    RESETn = 1'b0;
    #1;
    check("mid_q", {7'd0, Q}, {7'd0, IDLE});
    check("mid_qv", {7'd0, QV}, 8'd0);
    check("mid_req", {7'd0, REQ}, 8'd1);
    check("mid_ovf", {7'd0, OVF}, 8'd0);
    #1;
    RESETn = 1'b1;
    ce     = 1'b0;
    LD     = 1'b1;
    D      = 8'h81;
    @(negedge clk);
    LD = 1'b0;
    D  = 'x;
    check("post_rst_ld_req", {7'd0, REQ}, 8'd0);
    check("post_rst_qv", {7'd0, QV}, 8'd0);
    ce = 1'b1;
    @(negedge clk);
    expect_byte("post_rst", 8'h81);
    expect_idle("post_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
